// File: rtl/mux2_rr_arbiter.sv
// Purpose: two-input valid/ready arbiter feeding a one-deep output register and the downstream 2x1 mux select.
// Latency: 1 cycle from input handshake to out_valid; one word per cycle while out_ready is held high.
// Backpressure: inX_ready is driven only when the output register is empty or being drained this cycle.
// Build option: define MUX2_ARB_RR_EN for round-robin grant; otherwise channel 0 has fixed priority.
module mux2_rr_arbiter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [DW-1:0] in0_data,
  input  logic          in1_valid,
  output logic          in1_ready,
  input  logic [DW-1:0] in1_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          sel
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          sel_q, sel_d;
  logic          load;
  logic          gnt_vld;
  logic          gnt_ch;
  logic          xfer;

`ifdef MUX2_ARB_RR_EN
  // Last-granted channel; resets to 1 so channel 0 wins the first contention.
  logic last_q, last_d;

  // Grant: a lone requester wins; on contention the channel not granted last wins.
  always_comb begin
    gnt_vld = in0_valid | in1_valid;
    gnt_ch  = in1_valid & (~in0_valid | ~last_q);
  end

  // Priority only moves on an actual transfer, so idle cycles leave it alone.
  always_comb begin
    last_d = last_q;
    if (xfer) begin
      last_d = gnt_ch;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Grant: fixed priority, channel 0 wins whenever it requests.
  always_comb begin
    gnt_vld = in0_valid | in1_valid;
    gnt_ch  = in1_valid & ~in0_valid;
  end
`endif

  // Load when the register is empty or its word leaves this cycle; ready follows the grant.
  always_comb begin
    load      = (state_q == EMPTY) | out_ready;
    xfer      = load & gnt_vld;
    in0_ready = xfer & ~gnt_ch;
    in1_ready = xfer & gnt_ch;
  end

  // Output register next state: load the granted word, or drain to EMPTY keeping data/sel.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (load) begin
      if (gnt_vld) begin
        state_d = FULL;
        data_d  = gnt_ch ? in1_data : in0_data;
        sel_d   = gnt_ch;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // Output register; sel and data share the same edge so the mux select never skews from data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign sel       = sel_q;

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Registered two-input arbiter that sits directly upstream of the gate-level 2x1 mux. It accepts two valid/ready streams, chooses one per cycle, and presents the chosen word on a one-deep output register. It also drives `sel`, the select line that steers the downstream 2x1 mux. Full throughput: one word per cycle when the sink is always ready.

## Interface
Parameters:
- `DW`, 8, data width of each input and of the output

Ports:
- `clk`  in  1  rising-edge clock; the only clock
- `rst_n`  in  1  asynchronous active-low reset
- `in0_valid`  in  1  channel 0 offers a word
- `in0_ready`  out  1  channel 0 word is accepted this cycle
- `in0_data`  in  DW  channel 0 word
- `in1_valid`  in  1  channel 1 offers a word
- `in1_ready`  out  1  channel 1 word is accepted this cycle
- `in1_data`  in  DW  channel 1 word
- `out_valid`  out  1  output register holds a word
- `out_ready`  in  1  sink consumes the word this cycle
- `out_data`  out  DW  registered word
- `sel`  out  1  source channel of `out_data` (0 or 1); drives the downstream mux select

## Operation
- One clock, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values:
  - `out_valid`=0, `out_data`=0, `sel`=0.
  - Last-grant pointer `last`=1, so channel 0 has priority first.
- Output register states:
  - EMPTY (`out_valid`=0)
  - FULL (`out_valid`=1)
- Load enable: `load = !out_valid || out_ready`.
- Grant (combinational):
  - Only one `inX_valid` high: that channel wins.
  - Both high: the channel ≠ `last` wins.
  - Neither high: no grant.
- `inX_ready = load && grant==X`.
  - `inX_ready` may depend on `inX_valid`. A source must not wait for ready before asserting valid.
- Transfer occurs when `inX_valid && inX_ready`. At the next edge:
  - `out_data` ← `inX_data`
  - `sel` ← X
  - `out_valid` ← 1
  - `last` ← X
- When `load` is high and there is no grant:
  - `out_valid` ← 0.
  - `out_data` and `sel` hold their previous values.
- When FULL and `out_ready`=0: `out_data`, `sel`, `out_valid` hold stable. Both `inX_ready` are 0.
- `last` changes only on a transfer. Idle cycles do not move priority.
- No word is dropped or duplicated. Each accepted input word appears on the output exactly once, in acceptance order.

## Timing
- Latency: 1 cycle from input handshake to `out_valid`.
- Throughput: 1 word/cycle while `out_ready`=1. Consume and load may occur in the same cycle.
- Simultaneous requests with steady `out_ready`=1: grants alternate 0,1,0,1…
- `sel` changes only in the same edge as `out_data`. It never glitches relative to data at the register output.
- Reset asserted mid-transfer:
  - Outputs clear immediately (asynchronous).
  - The in-flight word is discarded.
  - `last` returns to 1.
- Reset deassertion is synchronised externally. The first active edge after release behaves as EMPTY.

## Configuration
- `MUX2_ARB_RR_EN` defined: round-robin grant as above.
- `MUX2_ARB_RR_EN` undefined: fixed priority, channel 0 always wins when both are valid. `last` is not implemented. All other behaviour is identical.

## Test plan
- Reset check: assert `rst_n`=0 mid-stream. Required: `out_valid`=0, `out_data`=0, `sel`=0 with no clock edge needed. After release, the first simultaneous request grants channel 0.
- Single source: `in0_valid`=1, data 0x11, 0x22, 0x33, `out_ready`=1. Required: outputs 0x11, 0x22, 0x33 on consecutive cycles, `sel`=0, `in1_ready`=0 throughout.
- Contention (RR build): both valid every cycle, in0 = 0xA0+n, in1 = 0xB0+n, `out_ready`=1. Required: output sequence 0xA0, 0xB0, 0xA1, 0xB1…, `sel` toggling 0,1,0,1.
- Backpressure: output FULL with 0x5A, hold `out_ready`=0 for 4 cycles with both inputs valid. Required: `out_data`=0x5A and `sel` stable, both `inX_ready`=0. On release, the next word loads in the same cycle as 0x5A is consumed.
- Bubble: single in1 word 0x7E, then no valid inputs. Required: `out_valid` high for one cycle with `sel`=1, then 0. `last` is unchanged during idle, so the next simultaneous request grants channel 0.
- Fixed-priority build (`MUX2_ARB_RR_EN` undefined): both valid for 3 cycles. Required: three channel-0 words, `in1_ready`=0 throughout.
